// File: rtl/cp0_access_ctrl.sv
// CP0 transaction sequencer between memory-stage commit and the CP0 register file.
// Optional feature: define CP0_CTRL_INT_EN to compile in interrupt detection and its priority slot.

package cp0_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        EXC   = 3'd1,
        BADVA = 3'd2,
        TLB   = 3'd3,
        ERET  = 3'd4,
        MTC0  = 3'd5,
        MFC0  = 3'd6
    } cp0_op_t;

    typedef struct packed {
        logic [31:0] epc;
        logic        cause_bd;
        logic [4:0]  cause_exccode;
        logic [31:0] badvaddr;
    } exc_info_t;

endpackage

module cp0_access_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_BASE_BEV = 32'hBFC00200,
    parameter logic [31:0] EXC_BASE_NRM = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_stall,
    input  logic        req_exc,
    input  logic [2:0]  req_exc_type,
    input  logic [4:0]  req_exc_code,
    input  logic        req_exc_bd,
    input  logic [31:0] req_exc_epc,
    input  logic [31:0] req_exc_badva,
    input  logic        req_tlb_refill,
    input  logic        req_eret,
    input  logic        req_mtc0,
    input  logic        req_mfc0,
    input  logic [4:0]  req_addr,
    input  logic [2:0]  req_sel,
    input  logic [31:0] req_wdata,
    output logic        req_ack,
    output logic        cp0_wen,
    output cp0_op_t     cp0_wtype,
    output exc_info_t   cp0_exc_info,
    output logic [4:0]  cp0_waddr,
    output logic [2:0]  cp0_wsel,
    output logic [31:0] cp0_wdata,
    output logic [4:0]  cp0_raddr,
    output logic [2:0]  cp0_rsel,
    input  logic        cp0_rready,
    input  logic [31:0] cp0_rdata,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mfc0_valid,
    output logic [31:0] mfc0_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    cp0_op_t     op_q,     op_d;
    logic [4:0]  addr_q,   addr_d;
    logic [2:0]  sel_q,    sel_d;
    logic [31:0] wdata_q,  wdata_d;
    exc_info_t   info_q,   info_d;
    logic [31:0] vector_q, vector_d;

    logic        int_pending;
    logic        any_req;
    logic        accept;
    logic        done;
    logic        refill_vec;
    logic [31:0] exc_base;
    logic        unused_bits;

`ifdef CP0_CTRL_INT_EN
    assign int_pending = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));
`else
    assign int_pending = 1'b0;
`endif

    // Most Status/Cause bits only matter to the interrupt check.
    assign unused_bits = ^{cp0_status, cp0_cause};

    assign any_req    = int_pending | req_exc | req_eret | req_mtc0 | req_mfc0;
    assign accept     = (state_q == IDLE) & any_req & cp0_rready & ~m_stall;
    assign exc_base   = cp0_status[22] ? EXC_BASE_BEV : EXC_BASE_NRM;
    // Refill vector only for a real TLB refill taken with EXL clear; interrupts never use it.
    assign refill_vec = ~int_pending & req_exc & (req_exc_type == TLB) & req_tlb_refill & ~cp0_status[1];

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        info_d   = info_q;
        vector_d = vector_q;

        req_ack        = 1'b0;
        cp0_wen        = 1'b0;
        cp0_wtype      = NONE;
        cp0_exc_info   = '0;
        cp0_waddr      = 5'd0;
        cp0_wsel       = 3'd0;
        cp0_wdata      = 32'd0;
        cp0_raddr      = 5'd0;
        cp0_rsel       = 3'd0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mfc0_valid     = 1'b0;
        mfc0_data      = 32'd0;
        done           = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ack  = 1'b1;
                    op_d     = NONE;
                    addr_d   = 5'd0;
                    sel_d    = 3'd0;
                    wdata_d  = 32'd0;
                    info_d   = '0;
                    vector_d = exc_base + (refill_vec ? 32'h0000_0000 : 32'h0000_0180);
                    state_d  = ISSUE;
                    if (int_pending) begin
                        op_d                 = EXC;
                        info_d.epc           = req_exc ? req_exc_epc : 32'd0;
                        info_d.cause_bd      = req_exc & req_exc_bd;
                        info_d.cause_exccode = 5'd0;
                    end else if (req_exc) begin
                        op_d                 = cp0_op_t'(req_exc_type);
                        info_d.epc           = req_exc_epc;
                        info_d.cause_bd      = req_exc_bd;
                        info_d.cause_exccode = req_exc_code;
                        info_d.badvaddr      = req_exc_badva;
                    end else if (req_eret) begin
                        op_d = ERET;
                    end else if (req_mtc0) begin
                        op_d    = MTC0;
                        addr_d  = req_addr;
                        sel_d   = req_sel;
                        wdata_d = req_wdata;
                    end else begin
                        op_d    = MFC0;
                        addr_d  = req_addr;
                        sel_d   = req_sel;
                        state_d = READ;
                    end
                end
            end
            ISSUE: begin
                cp0_wen      = 1'b1;
                cp0_wtype    = op_q;
                cp0_exc_info = info_q;
                cp0_waddr    = addr_q;
                cp0_wsel     = sel_q;
                cp0_wdata    = wdata_q;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cp0_rready) begin
                    done = 1'b1;
                    case (op_q)
                        EXC, BADVA, TLB: begin
                            flush          = 1'b1;
                            redirect_valid = 1'b1;
                            redirect_pc    = vector_q;
                        end
                        ERET: begin
                            flush          = 1'b1;
                            redirect_valid = 1'b1;
                            redirect_pc    = cp0_epc;
                        end
                        default: ;
                    endcase
                end
            end
            READ: begin
                cp0_raddr = addr_q;
                cp0_rsel  = sel_q;
                if (cp0_rready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                cp0_raddr  = addr_q;
                cp0_rsel   = sel_q;
                mfc0_valid = 1'b1;
                mfc0_data  = cp0_rdata;
                done       = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d  = IDLE;
            op_d     = NONE;
            addr_d   = 5'd0;
            sel_d    = 3'd0;
            wdata_d  = 32'd0;
            info_d   = '0;
            vector_d = 32'd0;
        end

        stall = (state_q == IDLE) ? any_req : ~done;

        // A reset cycle aborts whatever is in flight without letting a write or pulse escape.
        if (rst) begin
            req_ack        = 1'b0;
            cp0_wen        = 1'b0;
            cp0_wtype      = NONE;
            cp0_exc_info   = '0;
            cp0_waddr      = 5'd0;
            cp0_wsel       = 3'd0;
            cp0_wdata      = 32'd0;
            cp0_raddr      = 5'd0;
            cp0_rsel       = 3'd0;
            stall          = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'd0;
            mfc0_valid     = 1'b0;
            mfc0_data      = 32'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= NONE;
            addr_q   <= 5'd0;
            sel_q    <= 3'd0;
            wdata_q  <= 32'd0;
            info_q   <= '0;
            vector_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            info_q   <= info_d;
            vector_q <= vector_d;
        end
    end

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Scoreboard bench for cp0_access_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
// Includes a small CP0 register-file model (rready low for 2 cycles after each write, registered read data).

module tb_cp0_access_ctrl;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_stall;
    logic        req_exc;
    logic [2:0]  req_exc_type;
    logic [4:0]  req_exc_code;
    logic        req_exc_bd;
    logic [31:0] req_exc_epc;
    logic [31:0] req_exc_badva;
    logic        req_tlb_refill;
    logic        req_eret;
    logic        req_mtc0;
    logic        req_mfc0;
    logic [4:0]  req_addr;
    logic [2:0]  req_sel;
    logic [31:0] req_wdata;
    logic        req_ack;
    logic        cp0_wen;
    cp0_op_t     cp0_wtype;
    exc_info_t   cp0_exc_info;
    logic [4:0]  cp0_waddr;
    logic [2:0]  cp0_wsel;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [2:0]  cp0_rsel;
    logic        cp0_rready;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mfc0_valid;
    logic [31:0] mfc0_data;

    cp0_access_ctrl dut (
        .clk(clk), .rst(rst), .m_stall(m_stall),
        .req_exc(req_exc), .req_exc_type(req_exc_type), .req_exc_code(req_exc_code),
        .req_exc_bd(req_exc_bd), .req_exc_epc(req_exc_epc), .req_exc_badva(req_exc_badva),
        .req_tlb_refill(req_tlb_refill), .req_eret(req_eret), .req_mtc0(req_mtc0),
        .req_mfc0(req_mfc0), .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
        .req_ack(req_ack), .cp0_wen(cp0_wen), .cp0_wtype(cp0_wtype), .cp0_exc_info(cp0_exc_info),
        .cp0_waddr(cp0_waddr), .cp0_raddr(cp0_raddr), .cp0_wsel(cp0_wsel), .cp0_rsel(cp0_rsel),
        .cp0_wdata(cp0_wdata), .cp0_rready(cp0_rready), .cp0_rdata(cp0_rdata),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mfc0_valid(mfc0_valid), .mfc0_data(mfc0_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register-file model ----------------
    logic [31:0] regs [0:31];
    logic [1:0]  busy;
    logic [7:0]  hw_ip;
    logic        force_low;

    assign cp0_rready = (busy == 2'd0) && !force_low;
    assign cp0_status = regs[12];
    assign cp0_cause  = {regs[13][31:16], hw_ip, regs[13][7:0]};
    assign cp0_epc    = regs[14];

    always @(posedge clk) begin
        if (rst) begin
            busy      <= 2'd0;
            cp0_rdata <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            cp0_rdata <= regs[cp0_raddr];
            if (busy != 2'd0) busy <= busy - 2'd1;
            if (cp0_wen) begin
                busy <= 2'd2;
                case (cp0_wtype)
                    MTC0: regs[cp0_waddr] <= cp0_wdata;
                    EXC, BADVA, TLB: begin
                        regs[12][1]   <= 1'b1;
                        regs[14]      <= cp0_exc_info.epc;
                        regs[13][6:2] <= cp0_exc_info.cause_exccode;
                        regs[8]       <= cp0_exc_info.badvaddr;
                    end
                    ERET: regs[12][1] <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef enum int {EV_ACK, EV_WEN, EV_REDIR, EV_MFC0} ev_kind_t;
    typedef struct {
        string       name;
        ev_kind_t    kind;
        int          cyc;
        cp0_op_t     wtype;
        logic [4:0]  addr;
        logic [2:0]  sel;
        logic [31:0] data;
        exc_info_t   info;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic exc_info_t mk_info(logic [31:0] epc, logic bd, logic [4:0] code, logic [31:0] badva);
        exc_info_t r;
        r.epc = epc; r.cause_bd = bd; r.cause_exccode = code; r.badvaddr = badva;
        return r;
    endfunction

    task automatic push_ev(input string n, input ev_kind_t k, input int c, input cp0_op_t t,
                           input logic [4:0] a, input logic [2:0] s, input logic [31:0] d, input exc_info_t inf);
        ev_t e;
        e.name = n; e.kind = k; e.cyc = c; e.wtype = t; e.addr = a; e.sel = s; e.data = d; e.info = inf;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL spurious_event: got event kind %0d at cycle %0d, required none", k, cyc);
            return;
        end
        e = exp_q.pop_front();
        check({e.name, "_kind"}, k, e.kind);
        check({e.name, "_cycle"}, cyc, e.cyc);
        case (e.kind)
            EV_WEN: begin
                check({e.name, "_wtype"}, cp0_wtype, e.wtype);
                check({e.name, "_waddr"}, cp0_waddr, e.addr);
                check({e.name, "_wsel"}, cp0_wsel, e.sel);
                check({e.name, "_wdata"}, cp0_wdata, e.data);
                check({e.name, "_exc_info"}, cp0_exc_info, e.info);
            end
            EV_REDIR: begin
                check({e.name, "_flush"}, flush, 1'b1);
                check({e.name, "_redirect_valid"}, redirect_valid, 1'b1);
                check({e.name, "_redirect_pc"}, redirect_pc, e.data);
            end
            EV_MFC0: check({e.name, "_mfc0_data"}, mfc0_data, e.data);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (req_ack) expect_ev(EV_ACK);
        if (cp0_wen) expect_ev(EV_WEN);
        if (flush || redirect_valid) expect_ev(EV_REDIR);
        if (mfc0_valid) expect_ev(EV_MFC0);
        if (!redirect_valid) check("redirect_pc_idle", redirect_pc, 32'd0);
        if (!mfc0_valid) check("mfc0_data_idle", mfc0_data, 32'd0);
        if (!cp0_wen) check("wtype_idle", cp0_wtype, NONE);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_exc = 0; req_exc_type = 3'd0; req_exc_code = 5'd0; req_exc_bd = 0;
        req_exc_epc = 32'd0; req_exc_badva = 32'd0; req_tlb_refill = 0;
        req_eret = 0; req_mtc0 = 0; req_mfc0 = 0;
        req_addr = 5'd0; req_sel = 3'd0; req_wdata = 32'd0;
    endtask

    task automatic drive_mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        req_mtc0 = 1; req_addr = a; req_sel = s; req_wdata = d;
    endtask

    task automatic drive_exc(input cp0_op_t t, input logic [4:0] code, input logic bd,
                             input logic [31:0] epc, input logic [31:0] badva, input logic refill);
        req_exc = 1; req_exc_type = t; req_exc_code = code; req_exc_bd = bd;
        req_exc_epc = epc; req_exc_badva = badva; req_tlb_refill = refill;
    endtask

    // Write-type transaction already driven at the current cycle c: ack c, wen c+1, completion c+4.
    task automatic txn(input string name, input cp0_op_t wt, input logic [4:0] a, input logic [2:0] s,
                       input logic [31:0] d, input exc_info_t inf, input logic redir, input logic [31:0] rpc);
        int c;
        c = cyc;
        push_ev({name, "_ack"}, EV_ACK, c, NONE, 0, 0, 0, '0);
        push_ev({name, "_wen"}, EV_WEN, c + 1, wt, a, s, d, inf);
        if (redir) push_ev({name, "_redir"}, EV_REDIR, c + 4, NONE, 0, 0, rpc, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check({name, "_stall"}, stall, (i < 4));
            step();
            if (i == 0) clear_reqs();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_stall"}, stall, 1'b0);
        check({tag, "_req_ack"}, req_ack, 1'b0);
        check({tag, "_cp0_wen"}, cp0_wen, 1'b0);
        check({tag, "_cp0_wtype"}, cp0_wtype, NONE);
        check({tag, "_exc_info"}, cp0_exc_info, '0);
        check({tag, "_waddr_wdata"}, {cp0_waddr, cp0_wsel, cp0_wdata}, '0);
        check({tag, "_raddr"}, {cp0_raddr, cp0_rsel}, '0);
        check({tag, "_flush"}, flush, 1'b0);
        check({tag, "_redirect"}, {redirect_valid, redirect_pc}, '0);
        check({tag, "_mfc0"}, {mfc0_valid, mfc0_data}, '0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        rst = 1; m_stall = 0; hw_ip = 8'h00; force_low = 0;
        clear_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        step();
        rst = 0;
        @(negedge clk);
        chk_all_zero("post_reset");
        step();

        // MTC0 Status <- 0000FF01, then the next request accepted right after completion
        drive_mtc0(5'd12, 3'd0, 32'h0000FF01);
        txn("mtc0_status", MTC0, 5'd12, 3'd0, 32'h0000FF01, '0, 1'b0, 32'd0);

        // m_stall blocks acceptance for two cycles; then Status <- BEV=1, IE=0
        m_stall = 1;
        drive_mtc0(5'd12, 3'd0, 32'h0040FF00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mstall_hold_stall", stall, 1'b1);
            step();
        end
        m_stall = 0;
        txn("mtc0_bev", MTC0, 5'd12, 3'd0, 32'h0040FF00, '0, 1'b0, 32'd0);

        drive_mtc0(5'd16, 3'd2, 32'hDEADBEEF);
        txn("mtc0_sel2", MTC0, 5'd16, 3'd2, 32'hDEADBEEF, '0, 1'b0, 32'd0);

        // ExcCode 4, BEV=1, EXL=0, not refill
        drive_exc(BADVA, 5'd4, 1'b1, 32'hBFC01004, 32'h12345679, 1'b0);
        txn("exc_bev", BADVA, 5'd0, 3'd0, 32'd0, mk_info(32'hBFC01004, 1'b1, 5'd4, 32'h12345679),
            1'b1, 32'hBFC00380);

        // Status <- BEV=0, EXL=0; TLB refill -> 0x000 offset, then again with EXL=1 -> 0x180
        drive_mtc0(5'd12, 3'd0, 32'h0000FF00);
        txn("mtc0_nrm", MTC0, 5'd12, 3'd0, 32'h0000FF00, '0, 1'b0, 32'd0);
        drive_exc(TLB, 5'd2, 1'b0, 32'h80002000, 32'h00400000, 1'b1);
        txn("tlb_refill_exl0", TLB, 5'd0, 3'd0, 32'd0, mk_info(32'h80002000, 1'b0, 5'd2, 32'h00400000),
            1'b1, 32'h80000000);
        drive_exc(TLB, 5'd2, 1'b0, 32'h80002004, 32'h00400004, 1'b1);
        txn("tlb_refill_exl1", TLB, 5'd0, 3'd0, 32'd0, mk_info(32'h80002004, 1'b0, 5'd2, 32'h00400004),
            1'b1, 32'h80000180);

        // ERET returns to EPC
        drive_mtc0(5'd14, 3'd0, 32'h80001234);
        txn("mtc0_epc", MTC0, 5'd14, 3'd0, 32'h80001234, '0, 1'b0, 32'd0);
        req_eret = 1;
        txn("eret", ERET, 5'd0, 3'd0, 32'd0, '0, 1'b1, 32'h80001234);

        // Status <- IE=1, EXL=0, BEV=0
        drive_mtc0(5'd12, 3'd0, 32'h0000FF01);
        txn("mtc0_ie", MTC0, 5'd12, 3'd0, 32'h0000FF01, '0, 1'b0, 32'd0);

`ifdef CP0_CTRL_INT_EN
        // Interrupt, exception and ERET together: interrupt first, then exception, then ERET
        c = cyc;
        drive_exc(EXC, 5'd10, 1'b1, 32'h80003000, 32'd0, 1'b0);
        req_eret = 1;
        hw_ip = 8'h04;
        push_ev("prio_int_ack", EV_ACK, c, NONE, 0, 0, 0, '0);
        push_ev("prio_int_wen", EV_WEN, c + 1, EXC, 0, 0, 0, mk_info(32'h80003000, 1'b1, 5'd0, 32'd0));
        push_ev("prio_int_redir", EV_REDIR, c + 4, NONE, 0, 0, 32'h80000180, '0);
        push_ev("prio_exc_ack", EV_ACK, c + 5, NONE, 0, 0, 0, '0);
        push_ev("prio_exc_wen", EV_WEN, c + 6, EXC, 0, 0, 0, mk_info(32'h80003000, 1'b1, 5'd10, 32'd0));
        push_ev("prio_exc_redir", EV_REDIR, c + 9, NONE, 0, 0, 32'h80000180, '0);
        push_ev("prio_eret_ack", EV_ACK, c + 10, NONE, 0, 0, 0, '0);
        push_ev("prio_eret_wen", EV_WEN, c + 11, ERET, 0, 0, 0, '0);
        push_ev("prio_eret_redir", EV_REDIR, c + 14, NONE, 0, 0, 32'h80003000, '0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("prio_stall", stall, (i != 4) && (i != 9) && (i != 14));
            step();
            if (i == 0) hw_ip = 8'h00;
            if (i == 5) begin req_exc = 0; req_exc_type = 3'd0; req_exc_code = 5'd0;
                              req_exc_bd = 0; req_exc_epc = 32'd0; end
            if (i == 10) req_eret = 0;
        end
`else
        // Pending interrupt lines are ignored without the interrupt slot
        hw_ip = 8'h04;
        drive_mtc0(5'd9, 3'd0, 32'h00000000);
        txn("noint_mtc0", MTC0, 5'd9, 3'd0, 32'h00000000, '0, 1'b0, 32'd0);
        hw_ip = 8'h00;
`endif

        // MTC0 Count, MFC0 Count presented the next cycle; rready forced low while in READ
        c = cyc;
        drive_mtc0(5'd9, 3'd0, 32'h000000AB);
        push_ev("cnt_w_ack", EV_ACK, c, NONE, 0, 0, 0, '0);
        push_ev("cnt_w_wen", EV_WEN, c + 1, MTC0, 5'd9, 3'd0, 32'h000000AB, '0);
        push_ev("cnt_r_ack", EV_ACK, c + 5, NONE, 0, 0, 0, '0);
        push_ev("cnt_r_mfc0", EV_MFC0, c + 10, NONE, 0, 0, 32'h000000AB, '0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i != 4) check("mfc0_cnt_stall", stall, (i != 10));
            if (i >= 6) check("mfc0_cnt_raddr", cp0_raddr, 5'd9);
            step();
            if (i == 0) begin clear_reqs(); req_mfc0 = 1; req_addr = 5'd9; end
            if (i == 5) begin clear_reqs(); force_low = 1; end
            if (i == 8) force_low = 0;
        end

        // MFC0 Status with rready high: READ at c+1, data at c+2
        c = cyc;
        req_mfc0 = 1; req_addr = 5'd12;
        push_ev("st_r_ack", EV_ACK, c, NONE, 0, 0, 0, '0);
        push_ev("st_r_mfc0", EV_MFC0, c + 2, NONE, 0, 0, 32'h0000FF01, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mfc0_st_stall", stall, (i < 2));
            step();
            if (i == 0) clear_reqs();
        end

        // ERET aborted by reset while waiting on rready
        c = cyc;
        req_eret = 1;
        push_ev("rst_eret_ack", EV_ACK, c, NONE, 0, 0, 0, '0);
        push_ev("rst_eret_wen", EV_WEN, c + 1, ERET, 0, 0, 0, '0);
        @(negedge clk);
        step();
        clear_reqs();
        @(negedge clk);
        check("rst_eret_stall_issue", stall, 1'b1);
        step();
        rst = 1;
        @(negedge clk);
        chk_all_zero("rst_in_wait");
        step();
        rst = 0;
        @(negedge clk);
        chk_all_zero("after_rst");
        repeat (6) step();

        // Recovers normally after the abort
        drive_mtc0(5'd12, 3'd0, 32'h00000001);
        txn("post_rst_mtc0", MTC0, 5'd12, 3'd0, 32'h00000001, '0, 1'b0, 32'd0);

        repeat (3) step();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
